sync_debounce_bank: RTL and testbench

//   Parametrised multi-channel successor to the single-bit pulse synchronizer.
//   - Brings WIDTH asynchronous inputs (buttons, switches, external strobes) into the clk domain

---
 rtl/sync_debounce_bank.sv | 91 +++++++++
 tb/tb_sync_debounce_bank.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sync_debounce_bank.sv
// ============================================================================
// Module   : sync_debounce_bank
// Brief    : Per-channel flop-chain synchronizer plus counter debouncer, with
//            optional one-cycle rise/fall pulses (macro SYNC_DEBOUNCE_EDGE_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_debounce_bank #(
   parameter int WIDTH        = 4,
   parameter int NSYNC        = 2,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   localparam int            CW     = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] C_TERM = CW'(DEBOUNCE_CYC - 1);

   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] w_update;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i = i + 1) begin : g_chan
         logic [NSYNC-1:0] r_sync;
         logic [CW-1:0]    r_cnt;
         logic             r_lvl;

         // Plain shift chain: nothing may sit between these flops.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_sync <= '0;
            end else begin
               r_sync <= {r_sync[NSYNC-2:0], in[i]};
            end
         end

         assign w_s[i]      = r_sync[NSYNC-1];
         assign w_update[i] = (w_s[i] != r_lvl) && (r_cnt == C_TERM);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_cnt <= '0;
               r_lvl <= 1'b0;
            end else if (w_s[i] == r_lvl) begin
               r_cnt <= '0;
            end else if (r_cnt == C_TERM) begin
               r_cnt <= '0;
               r_lvl <= w_s[i];
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign out[i] = r_lvl;
      end
   endgenerate

`ifdef SYNC_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;

   // Registered alongside out, so a pulse coincides with the new level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_rise <= ~out & w_update &  w_s;
         r_fall <=  out & w_update & ~w_s;
      end
   end

   assign rise = r_rise;
   assign fall = r_fall;
`else
   logic w_unused;
   assign w_unused = ^w_update;
   assign rise     = {WIDTH{1'b0}};
   assign fall     = {WIDTH{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_debounce_bank.sv
// ============================================================================
// Module   : tb_sync_debounce_bank
// Brief    : Directed self-checking bench for sync_debounce_bank (4 ch, 2 sync,
//            debounce 4); pulse expectations follow SYNC_DEBOUNCE_EDGE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sync_debounce_bank;

`ifdef SYNC_DEBOUNCE_EDGE_EN
   localparam logic [3:0] C_EDGE = 4'hF;
`else
   localparam logic [3:0] C_EDGE = 4'h0;
`endif

   logic       clk;
   logic       reset;
   logic [3:0] in;
   logic [3:0] out;
   logic [3:0] rise;
   logic [3:0] fall;

   int n_cmp;
   int n_err;

   sync_debounce_bank #(
      .WIDTH        (4),
      .NSYNC        (2),
      .DEBOUNCE_CYC (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .out   (out),
      .rise  (rise),
      .fall  (fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps n edges with in held; out becomes chg at edge 'at', pulses on that edge only.
   task automatic window(input string tag, input int n, input logic [3:0] base,
                         input logic [3:0] chg, input int at,
                         input logic [3:0] rexp, input logic [3:0] fexp);
      for (int k = 1; k <= n; k++) begin
         step();
         check($sformatf("%s_out_e%0d", tag, k), 32'(out), 32'((k >= at) ? chg : base));
         check($sformatf("%s_rise_e%0d", tag, k), 32'(rise), 32'((k == at) ? (rexp & C_EDGE) : 4'h0));
         check($sformatf("%s_fall_e%0d", tag, k), 32'(fall), 32'((k == at) ? (fexp & C_EDGE) : 4'h0));
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      in    = 4'h0;
      step();
      step();
      check("rst_out", 32'(out), 32'h0);
      check("rst_rise", 32'(rise), 32'h0);
      check("rst_fall", 32'(fall), 32'h0);
      reset = 1'b0;

      // Single channel rise: out follows on edge 6.
      in = 4'b0001;
      window("ch0_rise", 8, 4'b0000, 4'b0001, 6, 4'b0001, 4'b0000);

      // 3-cycle glitch on ch1 must be rejected.
      in = 4'b0011;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 3) in = 4'b0001;
         check($sformatf("glitch_out_e%0d", k), 32'(out), 32'h1);
         check($sformatf("glitch_rise_e%0d", k), 32'(rise), 32'h0);
      end

      // Return ch0 to 0 (fall pulse), then simultaneous rise on ch3 and ch1.
      in = 4'b0000;
      window("ch0_fall", 8, 4'b0001, 4'b0000, 6, 4'b0000, 4'b0001);
      in = 4'b1010;
      window("multi", 8, 4'b0000, 4'b1010, 6, 4'b1010, 4'b0000);

      // ch2 bounces 1,0,1,0 then holds 1; final 0->1 sampled at edge 5.
      in = 4'b1110;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k <= 4) in[2] = (k % 2 == 0);
         check($sformatf("bounce_out_e%0d", k), 32'(out), 32'((k >= 10) ? 4'b1110 : 4'b1010));
         check($sformatf("bounce_rise_e%0d", k), 32'(rise),
               32'((k == 10) ? (4'b0100 & C_EDGE) : 4'h0));
      end

      // Drive all high, then async reset between edges.
      in = 4'hF;
      window("all_hi", 7, 4'b1110, 4'b1111, 6, 4'b0001, 4'b0000);
      #3;
      reset = 1'b1;
      #1;
      check("arst_out", 32'(out), 32'h0);
      check("arst_rise", 32'(rise), 32'h0);
      check("arst_fall", 32'(fall), 32'h0);
      step();
      check("arst_hold_out", 32'(out), 32'h0);
      step();
      check("arst_hold2_out", 32'(out), 32'h0);
      check("arst_hold2_rise", 32'(rise), 32'h0);
      reset = 1'b0;

      // After release the count restarts from scratch.
      window("post_rst", 8, 4'b0000, 4'b1111, 6, 4'b1111, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
